// File: rtl/channelizer_reload_ctrl.sv
// Coefficient reload sequencer for the polyphase channelizer: buffers a full tap set,
// gates the sample stream at a packet boundary, drains, then bursts the taps to the core.
module channelizer_reload_ctrl #(
    parameter int COEF_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 11,
    parameter int DRAIN_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH:0]   num_taps,
    input  logic [COEF_WIDTH-1:0] s_axis_coef_tdata,
    input  logic                  s_axis_coef_tlast,
    input  logic                  s_axis_coef_tvalid,
    output logic                  s_axis_coef_tready,
    output logic [COEF_WIDTH-1:0] m_axis_reload_tdata,
    output logic                  m_axis_reload_tlast,
    output logic                  m_axis_reload_tvalid,
    input  logic                  m_axis_reload_tready,
    input  logic                  s_axis_data_tvalid,
    input  logic                  s_axis_data_tlast,
    output logic                  s_axis_data_tready,
    output logic                  m_axis_data_tvalid,
    input  logic                  m_axis_data_tready,
    output logic                  busy,
    output logic                  reload_done,
    output logic                  count_err
);

    typedef enum logic [2:0] {IDLE, HOLD, DRAIN, RELOAD, DONE} state_t;

    localparam logic [ADDR_WIDTH:0]   PTR_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH+1:0] TOTAL_ONE  = {{(ADDR_WIDTH+1){1'b0}}, 1'b1};
    localparam logic [15:0]           DRAIN_LAST = 16'(DRAIN_CYCLES - 1);

    state_t                state;
    logic [COEF_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   taps;
    logic [ADDR_WIDTH+1:0] total;
    logic [15:0]           drain_cnt;
    logic                  ovf;
    logic                  pass;
    logic                  in_pkt;
    logic                  coef_xfer;
    logic                  data_xfer;
    logic                  reload_xfer;
    logic                  wr_full;
    logic                  load_word;
    logic                  pkt_open_next;

    assign s_axis_coef_tready = (state == IDLE);
    assign coef_xfer          = s_axis_coef_tvalid & s_axis_coef_tready;
    assign wr_full            = wr_ptr[ADDR_WIDTH];
    assign total              = {1'b0, wr_ptr} + TOTAL_ONE;

    assign m_axis_data_tvalid = s_axis_data_tvalid & pass;
    assign s_axis_data_tready = m_axis_data_tready & pass;
    assign data_xfer          = s_axis_data_tvalid & m_axis_data_tready & pass;
    assign pkt_open_next      = data_xfer ? ~s_axis_data_tlast : in_pkt;

    assign reload_xfer = m_axis_reload_tvalid & m_axis_reload_tready;
    // The output register doubles as the read-data stage, so a word is fetched whenever it is empty or draining.
    assign load_word   = (state == RELOAD) && (rd_ptr != taps) &&
                         (!m_axis_reload_tvalid || m_axis_reload_tready);

    always_ff @(posedge clk) begin
        if (coef_xfer && !wr_full) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= s_axis_coef_tdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_pkt <= 1'b0;
        end else begin
            in_pkt <= pkt_open_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                <= IDLE;
            wr_ptr               <= '0;
            rd_ptr               <= '0;
            taps                 <= '0;
            drain_cnt            <= '0;
            ovf                  <= 1'b0;
            pass                 <= 1'b1;
            m_axis_reload_tdata  <= '0;
            m_axis_reload_tlast  <= 1'b0;
            m_axis_reload_tvalid <= 1'b0;
            busy                 <= 1'b0;
            reload_done          <= 1'b0;
            count_err            <= 1'b0;
        end else begin
            reload_done <= 1'b0;
            count_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (coef_xfer) begin
                        if (s_axis_coef_tlast) begin
                            // The overflowing beat may itself be the tlast beat, hence wr_full here.
                            if (ovf || wr_full || (total != {1'b0, num_taps})) begin
                                count_err <= 1'b1;
                                wr_ptr    <= '0;
                                ovf       <= 1'b0;
                            end else begin
                                taps  <= num_taps;
                                busy  <= 1'b1;
                                state <= HOLD;
                            end
                        end else if (wr_full) begin
                            ovf <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + PTR_ONE;
                        end
                    end
                end
                HOLD: begin
                    if (!pkt_open_next) begin
                        pass      <= 1'b0;
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        rd_ptr <= '0;
                        state  <= RELOAD;
                    end else begin
                        drain_cnt <= drain_cnt + 16'd1;
                    end
                end
                RELOAD: begin
                    if (load_word) begin
                        m_axis_reload_tdata  <= mem[rd_ptr[ADDR_WIDTH-1:0]];
                        m_axis_reload_tlast  <= (rd_ptr == (taps - PTR_ONE));
                        m_axis_reload_tvalid <= 1'b1;
                        rd_ptr               <= rd_ptr + PTR_ONE;
                    end else if (reload_xfer) begin
                        m_axis_reload_tvalid <= 1'b0;
                        if (m_axis_reload_tlast) begin
                            m_axis_reload_tlast <= 1'b0;
                            reload_done         <= 1'b1;
                            busy                <= 1'b0;
                            state               <= DONE;
                        end
                    end
                end
                DONE: begin
                    pass   <= 1'b1;
                    wr_ptr <= '0;
                    ovf    <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_channelizer_reload_ctrl.sv
// Directed bench for channelizer_reload_ctrl: reload sequencing, packet-boundary gating,
// count errors, overflow, reload back-pressure and reset during a burst.
module tb_channelizer_reload_ctrl;

    localparam int CW = 32;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW:0]   num_taps;
    logic [CW-1:0] s_axis_coef_tdata;
    logic          s_axis_coef_tlast;
    logic          s_axis_coef_tvalid;
    logic          s_axis_coef_tready;
    logic [CW-1:0] m_axis_reload_tdata;
    logic          m_axis_reload_tlast;
    logic          m_axis_reload_tvalid;
    logic          m_axis_reload_tready;
    logic          s_axis_data_tvalid;
    logic          s_axis_data_tlast;
    logic          s_axis_data_tready;
    logic          m_axis_data_tvalid;
    logic          m_axis_data_tready;
    logic          busy;
    logic          reload_done;
    logic          count_err;

    channelizer_reload_ctrl #(.COEF_WIDTH(CW), .ADDR_WIDTH(AW), .DRAIN_CYCLES(64)) dut (
        .clk(clk), .reset(reset), .num_taps(num_taps),
        .s_axis_coef_tdata(s_axis_coef_tdata), .s_axis_coef_tlast(s_axis_coef_tlast),
        .s_axis_coef_tvalid(s_axis_coef_tvalid), .s_axis_coef_tready(s_axis_coef_tready),
        .m_axis_reload_tdata(m_axis_reload_tdata), .m_axis_reload_tlast(m_axis_reload_tlast),
        .m_axis_reload_tvalid(m_axis_reload_tvalid), .m_axis_reload_tready(m_axis_reload_tready),
        .s_axis_data_tvalid(s_axis_data_tvalid), .s_axis_data_tlast(s_axis_data_tlast),
        .s_axis_data_tready(s_axis_data_tready), .m_axis_data_tvalid(m_axis_data_tvalid),
        .m_axis_data_tready(m_axis_data_tready), .busy(busy), .reload_done(reload_done),
        .count_err(count_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run = 0;
    int tests_failed = 0;

    logic [CW-1:0] rl_q[$];
    logic          rl_last_q[$];
    int rl_first_cyc, stab_err, stall_cnt, done_cnt, done_cyc, err_cnt, err_cyc, busy_cnt;
    int coef_last_cyc, samp_cnt, samp_at_commit, samp_tlast_cyc, samp_at_gate, samp_at_done;
    int first_gate_cyc, after_done_cyc;
    logic          prev_stall = 1'b0;
    logic [CW-1:0] prev_data;
    logic          prev_last;

    // Observes everything at the falling edge, i.e. the values the next rising edge will act on.
    always @(negedge clk) begin
        if (m_axis_reload_tvalid && m_axis_reload_tready) begin
            rl_q.push_back(m_axis_reload_tdata);
            rl_last_q.push_back(m_axis_reload_tlast);
            if (rl_first_cyc < 0) rl_first_cyc = cyc;
        end
        if (prev_stall && (!m_axis_reload_tvalid || m_axis_reload_tdata !== prev_data ||
                           m_axis_reload_tlast !== prev_last)) stab_err++;
        prev_stall = m_axis_reload_tvalid && !m_axis_reload_tready;
        prev_data  = m_axis_reload_tdata;
        prev_last  = m_axis_reload_tlast;
        if (prev_stall) stall_cnt++;
        if (reload_done) begin
            done_cnt++;
            done_cyc = cyc;
            samp_at_done = samp_cnt;
        end
        if (count_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (busy) busy_cnt++;
        if (m_axis_data_tvalid && m_axis_data_tready) begin
            samp_cnt++;
            if (s_axis_data_tlast && samp_tlast_cyc < 0) begin
                samp_tlast_cyc = cyc;
                samp_at_gate = samp_cnt;
            end
            if (done_cyc >= 0 && after_done_cyc < 0) after_done_cyc = cyc;
        end
        if (s_axis_coef_tvalid && s_axis_coef_tready && s_axis_coef_tlast) begin
            coef_last_cyc = cyc;
            samp_at_commit = samp_cnt;
        end
        if (s_axis_data_tvalid && !m_axis_data_tvalid && first_gate_cyc < 0) first_gate_cyc = cyc;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        rl_q.delete();
        rl_last_q.delete();
        rl_first_cyc = -1; stab_err = 0; stall_cnt = 0; done_cnt = 0; done_cyc = -1;
        err_cnt = 0; err_cyc = -1; busy_cnt = 0; coef_last_cyc = -1; samp_cnt = 0;
        samp_at_commit = -1; samp_tlast_cyc = -1; samp_at_gate = -1; samp_at_done = -1;
        first_gate_cyc = -1; after_done_cyc = -1;
    endtask

    task automatic send_coefs(input int n, input logic [CW-1:0] base);
        for (int k = 0; k < n; k++) begin
            s_axis_coef_tvalid = 1'b1;
            s_axis_coef_tdata  = base + CW'(k);
            s_axis_coef_tlast  = (k == n - 1);
            step();
        end
        s_axis_coef_tvalid = 1'b0;
        s_axis_coef_tlast  = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit && done_cnt == 0; i++) step();
        repeat (3) step();
    endtask

    task automatic close_packet();
        s_axis_data_tvalid = 1'b1;
        s_axis_data_tlast  = 1'b1;
        m_axis_data_tready = 1'b1;
        step();
        s_axis_data_tvalid = 1'b0;
        s_axis_data_tlast  = 1'b0;
    endtask

    // Counts words that differ from base+k or carry tlast anywhere but the last position.
    function automatic int seq_errors(input logic [CW-1:0] base, input int n);
        int bad = 0;
        for (int k = 0; k < rl_q.size(); k++) begin
            if (rl_q[k] !== base + CW'(k) || rl_last_q[k] !== (k == n - 1)) bad++;
        end
        return bad;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        num_taps = '0; s_axis_coef_tdata = '0; s_axis_coef_tlast = 1'b0; s_axis_coef_tvalid = 1'b0;
        m_axis_reload_tready = 1'b1; s_axis_data_tlast = 1'b0;
        s_axis_data_tvalid = 1'b1; m_axis_data_tready = 1'b1;
        clear_mon();
        repeat (3) step();
        tests_run++;
        if (m_axis_reload_tvalid !== 1'b0 || m_axis_reload_tlast !== 1'b0 || m_axis_reload_tdata !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_reload_out: got v=%b l=%b d=%h expected 0/0/0",
                     m_axis_reload_tvalid, m_axis_reload_tlast, m_axis_reload_tdata);
        end
        tests_run++;
        if (busy !== 1'b0 || reload_done !== 1'b0 || count_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_status: got busy=%b done=%b err=%b expected 0/0/0", busy, reload_done, count_err);
        end
        tests_run++;
        if (m_axis_data_tvalid !== 1'b1 || s_axis_data_tready !== 1'b1 || s_axis_coef_tready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_pass_idle: got dv=%b dr=%b cr=%b expected 1/1/1",
                     m_axis_data_tvalid, s_axis_data_tready, s_axis_coef_tready);
        end
        reset = 1'b0;
        s_axis_data_tvalid = 1'b0;
        step();
    endtask

    task automatic test_basic_reload();
        clear_mon();
        num_taps = 4'd8;
        m_axis_reload_tready = 1'b1;
        send_coefs(8, 32'd1);
        tests_run++;
        if (busy !== 1'b1 || s_axis_coef_tready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL basic_busy_rise: got busy=%b cready=%b expected 1/0", busy, s_axis_coef_tready);
        end
        wait_done(200);
        tests_run++;
        if (done_cnt !== 1) begin
            tests_failed++;
            $display("[TB] FAIL basic_done_count: got %0d expected 1", done_cnt);
        end
        tests_run++;
        if (rl_q.size() !== 8 || seq_errors(32'd1, 8) !== 0) begin
            tests_failed++;
            $display("[TB] FAIL basic_sequence: got %0d words with %0d bad expected 8 with 0 bad",
                     rl_q.size(), seq_errors(32'd1, 8));
        end
        tests_run++;
        if (rl_first_cyc !== coef_last_cyc + 67) begin
            tests_failed++;
            $display("[TB] FAIL basic_first_word_cycle: got %0d expected %0d", rl_first_cyc, coef_last_cyc + 67);
        end
        tests_run++;
        if (done_cyc !== coef_last_cyc + 75) begin
            tests_failed++;
            $display("[TB] FAIL basic_done_cycle: got %0d expected %0d", done_cyc, coef_last_cyc + 75);
        end
        s_axis_data_tvalid = 1'b1;
        m_axis_data_tready = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || m_axis_data_tvalid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL basic_after_done: got busy=%b dvalid=%b expected 0/1", busy, m_axis_data_tvalid);
        end
        s_axis_data_tvalid = 1'b0;
        step();
    endtask

    task automatic test_packet_gating();
        int base;
        int post;
        clear_mon();
        base = samp_cnt;
        post = 0;
        num_taps = 4'd8;
        m_axis_reload_tready = 1'b1;
        s_axis_data_tvalid = 1'b1;
        m_axis_data_tready = 1'b1;
        for (int i = 0; i < 300 && post < 3; i++) begin
            s_axis_coef_tvalid = (i >= 2 && i <= 9);
            s_axis_coef_tdata  = 32'h10 + CW'(i - 2);
            s_axis_coef_tlast  = (i == 9);
            s_axis_data_tlast  = (((samp_cnt - base) % 32) == 31);
            step();
            if (done_cnt != 0) post++;
        end
        s_axis_coef_tvalid = 1'b0;
        s_axis_coef_tlast  = 1'b0;
        s_axis_data_tlast  = 1'b0;
        tests_run++;
        if (samp_at_commit - base !== 10 || samp_at_gate - samp_at_commit !== 22) begin
            tests_failed++;
            $display("[TB] FAIL pkt_beats: got before=%0d after=%0d expected 10/22",
                     samp_at_commit - base, samp_at_gate - samp_at_commit);
        end
        tests_run++;
        if (first_gate_cyc !== samp_tlast_cyc + 1) begin
            tests_failed++;
            $display("[TB] FAIL pkt_gate_cycle: got %0d expected %0d", first_gate_cyc, samp_tlast_cyc + 1);
        end
        tests_run++;
        if (done_cnt !== 1 || done_cyc !== samp_tlast_cyc + 74) begin
            tests_failed++;
            $display("[TB] FAIL pkt_done: got count=%0d cyc=%0d expected 1/%0d", done_cnt, done_cyc, samp_tlast_cyc + 74);
        end
        tests_run++;
        if (samp_at_done !== samp_at_gate || after_done_cyc !== done_cyc + 1) begin
            tests_failed++;
            $display("[TB] FAIL pkt_gated_flow: got leak=%0d resume=%0d expected 0/%0d",
                     samp_at_done - samp_at_gate, after_done_cyc, done_cyc + 1);
        end
        tests_run++;
        if (rl_q.size() !== 8 || seq_errors(32'h10, 8) !== 0) begin
            tests_failed++;
            $display("[TB] FAIL pkt_sequence: got %0d words with %0d bad expected 8 with 0 bad",
                     rl_q.size(), seq_errors(32'h10, 8));
        end
        close_packet();
    endtask

    task automatic test_short_set();
        clear_mon();
        num_taps = 4'd8;
        s_axis_data_tvalid = 1'b1;
        m_axis_data_tready = 1'b1;
        send_coefs(7, 32'h50);
        repeat (80) step();
        tests_run++;
        if (err_cnt !== 1 || err_cyc !== coef_last_cyc + 1) begin
            tests_failed++;
            $display("[TB] FAIL short_count_err: got count=%0d cyc=%0d expected 1/%0d", err_cnt, err_cyc, coef_last_cyc + 1);
        end
        tests_run++;
        if (busy_cnt !== 0 || rl_q.size() !== 0 || first_gate_cyc !== -1) begin
            tests_failed++;
            $display("[TB] FAIL short_no_reload: got busy=%0d words=%0d gate=%0d expected 0/0/-1",
                     busy_cnt, rl_q.size(), first_gate_cyc);
        end
        close_packet();
    endtask

    task automatic test_overflow();
        clear_mon();
        num_taps = 4'd8;
        send_coefs(10, 32'h60);
        repeat (80) step();
        tests_run++;
        if (err_cnt !== 1 || err_cyc !== coef_last_cyc + 1) begin
            tests_failed++;
            $display("[TB] FAIL ovf_count_err: got count=%0d cyc=%0d expected 1/%0d", err_cnt, err_cyc, coef_last_cyc + 1);
        end
        tests_run++;
        if (busy_cnt !== 0 || rl_q.size() !== 0) begin
            tests_failed++;
            $display("[TB] FAIL ovf_no_reload: got busy=%0d words=%0d expected 0/0", busy_cnt, rl_q.size());
        end
        clear_mon();
        send_coefs(8, 32'h100);
        wait_done(200);
        tests_run++;
        if (done_cnt !== 1 || err_cnt !== 0 || rl_q.size() !== 8 || seq_errors(32'h100, 8) !== 0) begin
            tests_failed++;
            $display("[TB] FAIL ovf_recover: got done=%0d err=%0d words=%0d bad=%0d expected 1/0/8/0",
                     done_cnt, err_cnt, rl_q.size(), seq_errors(32'h100, 8));
        end
    endtask

    task automatic test_backpressure();
        int k;
        clear_mon();
        num_taps = 4'd8;
        send_coefs(8, 32'h200);
        k = 0;
        for (int i = 0; i < 300 && done_cnt == 0; i++) begin
            m_axis_reload_tready = ((k % 4) == 0) || ((k % 4) == 3);
            k++;
            step();
        end
        m_axis_reload_tready = 1'b1;
        repeat (3) step();
        tests_run++;
        if (done_cnt !== 1 || rl_q.size() !== 8 || seq_errors(32'h200, 8) !== 0) begin
            tests_failed++;
            $display("[TB] FAIL bp_sequence: got done=%0d words=%0d bad=%0d expected 1/8/0",
                     done_cnt, rl_q.size(), seq_errors(32'h200, 8));
        end
        tests_run++;
        if (stab_err !== 0 || stall_cnt < 1) begin
            tests_failed++;
            $display("[TB] FAIL bp_stability: got unstable=%0d stalls=%0d expected 0/>0", stab_err, stall_cnt);
        end
    endtask

    task automatic test_reset_mid_reload();
        clear_mon();
        num_taps = 4'd8;
        m_axis_reload_tready = 1'b1;
        send_coefs(8, 32'h300);
        for (int i = 0; i < 200 && rl_q.size() < 2; i++) step();
        tests_run++;
        if (rl_q.size() !== 2 || m_axis_reload_tvalid !== 1'b1 || m_axis_reload_tdata !== 32'h302) begin
            tests_failed++;
            $display("[TB] FAIL rst_third_word: got words=%0d v=%b d=%h expected 2/1/00000302",
                     rl_q.size(), m_axis_reload_tvalid, m_axis_reload_tdata);
        end
        s_axis_data_tvalid = 1'b1;
        m_axis_data_tready = 1'b1;
        reset = 1'b1;
        #1;
        tests_run++;
        if (m_axis_reload_tvalid !== 1'b0 || busy !== 1'b0 || m_axis_data_tvalid !== 1'b1 || s_axis_coef_tready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL rst_abort: got v=%b busy=%b dvalid=%b cready=%b expected 0/0/1/1",
                     m_axis_reload_tvalid, busy, m_axis_data_tvalid, s_axis_coef_tready);
        end
        step();
        reset = 1'b0;
        s_axis_data_tvalid = 1'b0;
        step();
        clear_mon();
        send_coefs(8, 32'h400);
        wait_done(200);
        tests_run++;
        if (done_cnt !== 1 || rl_q.size() !== 8 || seq_errors(32'h400, 8) !== 0) begin
            tests_failed++;
            $display("[TB] FAIL rst_fresh_set: got done=%0d words=%0d bad=%0d expected 1/8/0",
                     done_cnt, rl_q.size(), seq_errors(32'h400, 8));
        end
    endtask

    initial begin
        test_reset();
        test_basic_reload();
        test_packet_gating();
        test_short_set();
        test_overflow();
        test_backpressure();
        test_reset_mid_reload();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
